aes_top: RTL and testbench



---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_core.sv | 82 ++++++++
 rtl/aes_top.sv | 88 ++++++++
 tb/tb_aes_top.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, FSM state enums, S-box,
// GF(2^8) helpers, round-constant table and the MixColumns column transform.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {IDLE, RUN1, RUN2, CHECK} top_state_t;
    typedef enum logic       {C_IDLE, C_RUN}           core_state_t;

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        case (rnd)
            4'd1: r = 8'h01;  4'd2: r = 8'h02;  4'd3: r = 8'h04;  4'd4:  r = 8'h08;
            4'd5: r = 8'h10;  4'd6: r = 8'h20;  4'd7: r = 8'h40;  4'd8:  r = 8'h80;
            4'd9: r = 8'h1b;  4'd10: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One column of MixColumns, bytes ordered row 0 at the MSB.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s=8'h63; 8'h01: s=8'h7c; 8'h02: s=8'h77; 8'h03: s=8'h7b; 8'h04: s=8'hf2; 8'h05: s=8'h6b; 8'h06: s=8'h6f; 8'h07: s=8'hc5;
            8'h08: s=8'h30; 8'h09: s=8'h01; 8'h0a: s=8'h67; 8'h0b: s=8'h2b; 8'h0c: s=8'hfe; 8'h0d: s=8'hd7; 8'h0e: s=8'hab; 8'h0f: s=8'h76;
            8'h10: s=8'hca; 8'h11: s=8'h82; 8'h12: s=8'hc9; 8'h13: s=8'h7d; 8'h14: s=8'hfa; 8'h15: s=8'h59; 8'h16: s=8'h47; 8'h17: s=8'hf0;
            8'h18: s=8'had; 8'h19: s=8'hd4; 8'h1a: s=8'ha2; 8'h1b: s=8'haf; 8'h1c: s=8'h9c; 8'h1d: s=8'ha4; 8'h1e: s=8'h72; 8'h1f: s=8'hc0;
            8'h20: s=8'hb7; 8'h21: s=8'hfd; 8'h22: s=8'h93; 8'h23: s=8'h26; 8'h24: s=8'h36; 8'h25: s=8'h3f; 8'h26: s=8'hf7; 8'h27: s=8'hcc;
            8'h28: s=8'h34; 8'h29: s=8'ha5; 8'h2a: s=8'he5; 8'h2b: s=8'hf1; 8'h2c: s=8'h71; 8'h2d: s=8'hd8; 8'h2e: s=8'h31; 8'h2f: s=8'h15;
            8'h30: s=8'h04; 8'h31: s=8'hc7; 8'h32: s=8'h23; 8'h33: s=8'hc3; 8'h34: s=8'h18; 8'h35: s=8'h96; 8'h36: s=8'h05; 8'h37: s=8'h9a;
            8'h38: s=8'h07; 8'h39: s=8'h12; 8'h3a: s=8'h80; 8'h3b: s=8'he2; 8'h3c: s=8'heb; 8'h3d: s=8'h27; 8'h3e: s=8'hb2; 8'h3f: s=8'h75;
            8'h40: s=8'h09; 8'h41: s=8'h83; 8'h42: s=8'h2c; 8'h43: s=8'h1a; 8'h44: s=8'h1b; 8'h45: s=8'h6e; 8'h46: s=8'h5a; 8'h47: s=8'ha0;
            8'h48: s=8'h52; 8'h49: s=8'h3b; 8'h4a: s=8'hd6; 8'h4b: s=8'hb3; 8'h4c: s=8'h29; 8'h4d: s=8'he3; 8'h4e: s=8'h2f; 8'h4f: s=8'h84;
            8'h50: s=8'h53; 8'h51: s=8'hd1; 8'h52: s=8'h00; 8'h53: s=8'hed; 8'h54: s=8'h20; 8'h55: s=8'hfc; 8'h56: s=8'hb1; 8'h57: s=8'h5b;
            8'h58: s=8'h6a; 8'h59: s=8'hcb; 8'h5a: s=8'hbe; 8'h5b: s=8'h39; 8'h5c: s=8'h4a; 8'h5d: s=8'h4c; 8'h5e: s=8'h58; 8'h5f: s=8'hcf;
            8'h60: s=8'hd0; 8'h61: s=8'hef; 8'h62: s=8'haa; 8'h63: s=8'hfb; 8'h64: s=8'h43; 8'h65: s=8'h4d; 8'h66: s=8'h33; 8'h67: s=8'h85;
            8'h68: s=8'h45; 8'h69: s=8'hf9; 8'h6a: s=8'h02; 8'h6b: s=8'h7f; 8'h6c: s=8'h50; 8'h6d: s=8'h3c; 8'h6e: s=8'h9f; 8'h6f: s=8'ha8;
            8'h70: s=8'h51; 8'h71: s=8'ha3; 8'h72: s=8'h40; 8'h73: s=8'h8f; 8'h74: s=8'h92; 8'h75: s=8'h9d; 8'h76: s=8'h38; 8'h77: s=8'hf5;
            8'h78: s=8'hbc; 8'h79: s=8'hb6; 8'h7a: s=8'hda; 8'h7b: s=8'h21; 8'h7c: s=8'h10; 8'h7d: s=8'hff; 8'h7e: s=8'hf3; 8'h7f: s=8'hd2;
            8'h80: s=8'hcd; 8'h81: s=8'h0c; 8'h82: s=8'h13; 8'h83: s=8'hec; 8'h84: s=8'h5f; 8'h85: s=8'h97; 8'h86: s=8'h44; 8'h87: s=8'h17;
            8'h88: s=8'hc4; 8'h89: s=8'ha7; 8'h8a: s=8'h7e; 8'h8b: s=8'h3d; 8'h8c: s=8'h64; 8'h8d: s=8'h5d; 8'h8e: s=8'h19; 8'h8f: s=8'h73;
            8'h90: s=8'h60; 8'h91: s=8'h81; 8'h92: s=8'h4f; 8'h93: s=8'hdc; 8'h94: s=8'h22; 8'h95: s=8'h2a; 8'h96: s=8'h90; 8'h97: s=8'h88;
            8'h98: s=8'h46; 8'h99: s=8'hee; 8'h9a: s=8'hb8; 8'h9b: s=8'h14; 8'h9c: s=8'hde; 8'h9d: s=8'h5e; 8'h9e: s=8'h0b; 8'h9f: s=8'hdb;
            8'ha0: s=8'he0; 8'ha1: s=8'h32; 8'ha2: s=8'h3a; 8'ha3: s=8'h0a; 8'ha4: s=8'h49; 8'ha5: s=8'h06; 8'ha6: s=8'h24; 8'ha7: s=8'h5c;
            8'ha8: s=8'hc2; 8'ha9: s=8'hd3; 8'haa: s=8'hac; 8'hab: s=8'h62; 8'hac: s=8'h91; 8'had: s=8'h95; 8'hae: s=8'he4; 8'haf: s=8'h79;
            8'hb0: s=8'he7; 8'hb1: s=8'hc8; 8'hb2: s=8'h37; 8'hb3: s=8'h6d; 8'hb4: s=8'h8d; 8'hb5: s=8'hd5; 8'hb6: s=8'h4e; 8'hb7: s=8'ha9;
            8'hb8: s=8'h6c; 8'hb9: s=8'h56; 8'hba: s=8'hf4; 8'hbb: s=8'hea; 8'hbc: s=8'h65; 8'hbd: s=8'h7a; 8'hbe: s=8'hae; 8'hbf: s=8'h08;
            8'hc0: s=8'hba; 8'hc1: s=8'h78; 8'hc2: s=8'h25; 8'hc3: s=8'h2e; 8'hc4: s=8'h1c; 8'hc5: s=8'ha6; 8'hc6: s=8'hb4; 8'hc7: s=8'hc6;
            8'hc8: s=8'he8; 8'hc9: s=8'hdd; 8'hca: s=8'h74; 8'hcb: s=8'h1f; 8'hcc: s=8'h4b; 8'hcd: s=8'hbd; 8'hce: s=8'h8b; 8'hcf: s=8'h8a;
            8'hd0: s=8'h70; 8'hd1: s=8'h3e; 8'hd2: s=8'hb5; 8'hd3: s=8'h66; 8'hd4: s=8'h48; 8'hd5: s=8'h03; 8'hd6: s=8'hf6; 8'hd7: s=8'h0e;
            8'hd8: s=8'h61; 8'hd9: s=8'h35; 8'hda: s=8'h57; 8'hdb: s=8'hb9; 8'hdc: s=8'h86; 8'hdd: s=8'hc1; 8'hde: s=8'h1d; 8'hdf: s=8'h9e;
            8'he0: s=8'he1; 8'he1: s=8'hf8; 8'he2: s=8'h98; 8'he3: s=8'h11; 8'he4: s=8'h69; 8'he5: s=8'hd9; 8'he6: s=8'h8e; 8'he7: s=8'h94;
            8'he8: s=8'h9b; 8'he9: s=8'h1e; 8'hea: s=8'h87; 8'heb: s=8'he9; 8'hec: s=8'hce; 8'hed: s=8'h55; 8'hee: s=8'h28; 8'hef: s=8'hdf;
            8'hf0: s=8'h8c; 8'hf1: s=8'ha1; 8'hf2: s=8'h89; 8'hf3: s=8'h0d; 8'hf4: s=8'hbf; 8'hf5: s=8'he6; 8'hf6: s=8'h42; 8'hf7: s=8'h68;
            8'hf8: s=8'h41; 8'hf9: s=8'h99; 8'hfa: s=8'h2d; 8'hfb: s=8'h0f; 8'hfc: s=8'hb0; 8'hfd: s=8'h54; 8'hfe: s=8'hbb; 8'hff: s=8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_core.sv
// Iterative AES-128 round core: one round per clock, round keys expanded on the fly.
// Ports: clk, rst (sync, active high), start (load block_in^key), key, block_in,
//        done (one-cycle pulse once the result is in state_reg), block_out (= state_reg).
module aes_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] block_in,
    output logic         done,
    output logic [127:0] block_out
);

    core_state_t  cst, cst_next;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [3:0]   round;

    logic [31:0]  rk_w3, tmp_w, nw0, nw1, nw2, nw3;
    logic [127:0] rk_next, sr, mc, rnd_out;

    // Next round key from the current one.
    assign rk_w3   = rk_reg[31:0];
    assign tmp_w   = {sbox(rk_w3[23:16]), sbox(rk_w3[15:8]), sbox(rk_w3[7:0]), sbox(rk_w3[31:24])}
                   ^ {rcon(round), 24'h0};
    assign nw0     = rk_reg[127:96] ^ tmp_w;
    assign nw1     = rk_reg[95:64]  ^ nw0;
    assign nw2     = rk_reg[63:32]  ^ nw1;
    assign nw3     = rk_reg[31:0]   ^ nw2;
    assign rk_next = {nw0, nw1, nw2, nw3};

    // SubBytes + ShiftRows: byte i sits at row i%4, column i/4; row r is
    // rotated left by r, so it takes its byte from column (c + r) % 4.
    always_comb begin
        sr = '0;
        for (int i = 0; i < 16; i++) begin
            sr[127-8*i -: 8] = sbox(state_reg[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
        end
    end

    assign mc = {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};

    // Final round skips MixColumns.
    assign rnd_out = ((round == NR) ? sr : mc) ^ rk_next;

    always_comb begin
        cst_next = cst;
        case (cst)
            C_IDLE:  if (start) cst_next = C_RUN;
            C_RUN:   if (!start && round == NR) cst_next = C_IDLE;
            default: cst_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cst       <= C_IDLE;
            state_reg <= '0;
            rk_reg    <= '0;
            round     <= '0;
            done      <= 1'b0;
        end else begin
            cst  <= cst_next;
            done <= 1'b0;
            if (start) begin
                state_reg <= block_in ^ key;
                rk_reg    <= key;
                round     <= 4'd1;
            end else if (cst == C_RUN) begin
                state_reg <= rnd_out;
                rk_reg    <= rk_next;
                round     <= round + 4'd1;
                done      <= (round == NR);
            end
        end
    end

    assign block_out = state_reg;

endmodule

// File: rtl/aes_top.sv
// AES-128 encryption with temporal redundancy: each request is encrypted twice
// on u_core and the results compared; a mismatch sets fault_flag and zeroes ciphertext.
// Ports: clk, rst (sync, active high), start, key, plaintext (inputs);
//        busy, done (1-cycle pulse), ciphertext, fault_flag (held until next accepted start).
module aes_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic         fault_flag
);

    top_state_t   st, st_next;
    logic [127:0] key_q, pt_q, ct1, ct2, core_out;
    logic         launch, core_start, core_done, accept;

    assign accept = (st == IDLE) && start;

    // First run launches the cycle after the inputs are latched; the second run
    // relaunches on the same edge that captures the first result.
    assign core_start = launch | ((st == RUN1) && core_done);

    // The core holds its result in state_reg until relaunched, so the second
    // result is read straight from it.
    assign ct2 = core_out;

    aes_core u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .key       (key_q),
        .block_in  (pt_q),
        .done      (core_done),
        .block_out (core_out)
    );

    always_comb begin
        st_next = st;
        case (st)
            IDLE:    if (start)     st_next = RUN1;
            RUN1:    if (core_done) st_next = RUN2;
            RUN2:    if (core_done) st_next = CHECK;
            CHECK:                  st_next = IDLE;
            default:                st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            key_q      <= '0;
            pt_q       <= '0;
            ct1        <= '0;
            launch     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ciphertext <= '0;
            fault_flag <= 1'b0;
        end else begin
            st     <= st_next;
            launch <= accept;
            done   <= 1'b0;
            if (accept) begin
                key_q      <= key;
                pt_q       <= plaintext;
                ciphertext <= '0;
                fault_flag <= 1'b0;
                busy       <= 1'b1;
            end
            if ((st == RUN1) && core_done) ct1 <= core_out;
            // Outputs are registered on the edge that enters CHECK, so done is
            // visible during the CHECK cycle.
            if ((st == RUN2) && core_done) begin
                ciphertext <= (ct1 == ct2) ? ct1 : '0;
                fault_flag <= (ct1 != ct2);
                done       <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_top.sv
module tb_aes_top;

    logic         clk = 1'b0;
    logic         rst, start, busy, done, fault_flag;
    logic [127:0] key, plaintext, ciphertext;
    logic [127:0] inj_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_ref [256];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_top dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .fault_flag (fault_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Generic GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] coef [4];
        logic [7:0] rc, t0, acc;
        logic [127:0] r;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8] ^ w[i];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tw[0];
                tw[0] = sb_ref[tw[1]] ^ rc;
                tw[1] = sb_ref[tw[2]];
                tw[2] = sb_ref[tw[3]];
                tw[3] = sb_ref[t0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tw[j];
        end
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[rr+4*c] = sb_ref[s[rr + 4*((c+rr) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) begin
                    if (rd < 10) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc ^= gm(coef[(j - rr + 4) % 4], t[j+4*c]);
                    end else begin
                        acc = t[rr+4*c];
                    end
                    s[rr+4*c] = acc ^ w[16*rd + rr + 4*c];
                end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request and watch 30 cycles. inj_at/poke_at = 0 disables the
    // state corruption / mid-operation start. lat = cycle of first done (-1 if none).
    task automatic run_op(input logic [127:0] k, input logic [127:0] p,
                          input int inj_at, input logic [127:0] inj_mask, input int poke_at,
                          output int lat, output int ndone, output logic [127:0] ct,
                          output logic ff, output logic bsy_mid, output logic bsy_after);
        lat = -1; ndone = 0; ct = '0; ff = 1'b0; bsy_mid = 1'b0; bsy_after = 1'b1;
        key = k; plaintext = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key = rnd128(); plaintext = rnd128();
        for (int c = 1; c <= 30; c++) begin
            if (c == inj_at) begin
                inj_val = dut.u_core.state_reg ^ inj_mask;
                force dut.u_core.state_reg = inj_val;
            end
            if (c == poke_at) begin start = 1'b1; key = ~k; end
            @(posedge clk); #1;
            if (c == inj_at) release dut.u_core.state_reg;
            if (c == poke_at) start = 1'b0;
            if (c == 10) bsy_mid = busy;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c; ct = ciphertext; ff = fault_flag; bsy_after = busy;
                end
            end
        end
    endtask

    initial begin
        int lat, nd;
        logic [127:0] ct, kr, pr;
        logic ff, bm, ba;

        build_sbox();
        rst = 1'b1; start = 1'b0; key = '0; plaintext = '0; inj_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_ct",   ciphertext, 128'd0);
        check("reset_ff",   128'(fault_flag), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 C.1
        run_op(K1, P1, 0, '0, 0, lat, nd, ct, ff, bm, ba);
        check("c1_latency", 128'(lat), 128'd23);
        check("c1_ct", ct, C1);
        check("c1_ff", 128'(ff), 128'd0);
        check("c1_busy_mid", 128'(bm), 128'd1);
        check("c1_busy_after", 128'(ba), 128'd0);
        check("c1_ndone", 128'(nd), 128'd1);

        // FIPS-197 B
        run_op(K2, P2, 0, '0, 0, lat, nd, ct, ff, bm, ba);
        check("b_ct", ct, C2);
        check("b_ff", 128'(ff), 128'd0);

        // Corruption during run 1
        run_op(K1, P1, 4, 128'h1, 0, lat, nd, ct, ff, bm, ba);
        check("f1_latency", 128'(lat), 128'd23);
        check("f1_ff", 128'(ff), 128'd1);
        check("f1_ct", ct, 128'd0);

        // Corruption during run 2, then a clean request
        run_op(K1, P1, 15, {1'b1, 127'd0}, 0, lat, nd, ct, ff, bm, ba);
        check("f2_ff", 128'(ff), 128'd1);
        check("f2_ct", ct, 128'd0);
        run_op(K1, P1, 0, '0, 0, lat, nd, ct, ff, bm, ba);
        check("after_fault_ct", ct, C1);
        check("after_fault_ff", 128'(ff), 128'd0);

        // Start while busy is ignored
        run_op(K1, P1, 0, '0, 8, lat, nd, ct, ff, bm, ba);
        check("busy_start_latency", 128'(lat), 128'd23);
        check("busy_start_ct", ct, C1);
        check("busy_start_ndone", 128'(nd), 128'd1);

        // Reset mid-operation at E0+10
        key = K2; plaintext = P2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        check("midrst_ct",   ciphertext, 128'd0);
        check("midrst_ff",   128'(fault_flag), 128'd0);
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midrst_no_done", 128'(nd), 128'd0);
        run_op(K2, P2, 0, '0, 0, lat, nd, ct, ff, bm, ba);
        check("midrst_next_ct", ct, C2);
        check("midrst_next_ff", 128'(ff), 128'd0);

        // Random requests against the reference model
        for (int n = 0; n < 6; n++) begin
            kr = rnd128();
            pr = rnd128();
            run_op(kr, pr, 0, '0, 0, lat, nd, ct, ff, bm, ba);
            check("rand_ct", ct, aes_ref(kr, pr));
            check("rand_ff", 128'(ff), 128'd0);
            check("rand_latency", 128'(lat), 128'd23);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
